// File: rtl/i2c_target_regfile.sv
// I2C target with 7-bit address match and byte-wide register file.
// SCL/SDA are oversampled on clk; pointer byte first, then data bytes.
`timescale 1ns/1ps
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'b0101010,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_scl,
  inout  wire           i2c_sda,
  output logic          reg_wr_en,
  output logic [AW-1:0] reg_wr_addr,
  output logic [7:0]    reg_wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;

  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          rw_q, rw_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NUM_REGS];

  logic          scl_s, sda_s;
  logic          scl_rise, scl_fall;
  logic          sda_rise, sda_fall;
  logic          start_c, stop_c;
  logic [7:0]    in_byte;
  logic [7:0]    rd_byte;
  logic [7:0]    nxt_byte;
  logic [AW-1:0] nxt_ptr;

  // Sync chain is left unreset so a reset never fakes a bus edge
  always_ff @(posedge clk) begin
    scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_scl};
    sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sda};
    scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
    sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign sda_rise = sda_s & ~sda_hist_q;
  assign sda_fall = ~sda_s & sda_hist_q;
  // SCL must be stable high across the SDA edge
  assign start_c  = sda_fall & scl_s & scl_hist_q;
  assign stop_c   = sda_rise & scl_s & scl_hist_q;

  assign in_byte  = {sh_q[6:0], sda_s};
  assign rd_byte  = regs_q[ptr_q];
  assign nxt_ptr  = ptr_q + AW'(1);
  assign nxt_byte = regs_q[nxt_ptr];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: oe_d = 1'b0;
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            sh_d  = in_byte;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              unique case (state_q)
                ADDR: begin
                  if (in_byte[7:1] == TARGET_ADDR) begin
                    rw_d    = in_byte[0];
                    busy_d  = 1'b1;
                    state_d = ADDR_ACK;
                  end else begin
                    busy_d  = 1'b0;
                    state_d = WAIT_STOP;
                  end
                end
                PTR: begin
                  ptr_d   = in_byte[AW-1:0];
                  state_d = PTR_ACK;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = in_byte;
                  ptr_d     = nxt_ptr;
                  state_d   = WDATA_ACK;
                end
              endcase
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d  = 1'b1;
              cnt_d = 4'd1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = '0;
              if (state_q != ADDR_ACK) begin
                state_d = WDATA;
              end else if (!rw_q) begin
                state_d = PTR;
              end else begin
                // First read bit goes out on this same falling edge
                oe_d    = ~rd_byte[7];
                sh_d    = {rd_byte[6:0], 1'b0};
                cnt_d   = 4'd1;
                state_d = RDATA;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = '0;
              state_d = RACK;
            end else begin
              oe_d  = ~sh_q[7];
              sh_d  = {sh_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            ptr_d = nxt_ptr;
            if (!sda_s) begin
              sh_d    = nxt_byte;
              cnt_d   = '0;
              state_d = RDATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (wr_en_d) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  assign i2c_sda     = oe_q ? 1'b0 : 1'bz;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged initiator,
// register model and queues of expected ACKs, read bytes and writes.
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_oe = 1'b0;
  wire        sda;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  pullup (sda);
  assign sda = tb_oe ? 1'b0 : 1'bz;

  i2c_target_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .i2c_scl    (scl),
    .i2c_sda    (sda),
    .reg_wr_en  (wr_en),
    .reg_wr_addr(wr_addr),
    .reg_wr_data(wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int npulse = 0;
  int nexp = 0;

  logic [31:0] ack_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_q[$];
  logic [7:0]  mregs [16];
  logic [3:0]  mptr = '0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      logic [31:0] e;
      npulse++;
      e = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hFFFF_FFFF;
      check("wr_pulse", {20'd0, wr_addr, wr_data}, e);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    tb_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    tb_oe = 1'b1; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    tb_oe = 1'b1; #Q;
    scl = 1'b1; #Q;
    tb_oe = 1'b0; #Q;
  endtask

  task automatic wbit(input logic b);
    tb_oe = ~b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic rbit(output logic b);
    tb_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    b = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, input logic ack, input string tag);
    logic a;
    ack_q.push_back({31'd0, ack});
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    check(tag, {31'd0, ~a}, ack_q.pop_front());
  endtask

  task automatic wptr(input logic [7:0] p);
    mptr = p[3:0];
    wbyte(p, 1'b1, "ptr_ack");
  endtask

  task automatic wdata(input logic [7:0] d);
    wr_q.push_back({20'd0, mptr, d});
    nexp++;
    mregs[mptr] = d;
    mptr = mptr + 4'd1;
    wbyte(d, 1'b1, "wdata_ack");
  endtask

  task automatic rbyte(input logic ack, input string tag);
    logic [7:0] d;
    logic b;
    rd_q.push_back({24'd0, mregs[mptr]});
    mptr = mptr + 4'd1;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~ack);
    check(tag, {24'd0, d}, rd_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sda", {31'd0, sda}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    i2c_start();
    wbyte(8'h54, 1'b1, "t1_addr_ack");
    check("t1_busy", {31'd0, busy}, 32'd1);
    wptr(8'h03);
    wdata(8'hFF);
    i2c_stop();
    repeat (8) @(negedge clk);
    check("t1_busy_low", {31'd0, busy}, 32'd0);

    i2c_start();
    wbyte(8'h54, 1'b1, "t2_addr_ack");
    wptr(8'h03);
    i2c_stop();
    i2c_start();
    wbyte(8'h55, 1'b1, "t2_raddr_ack");
    rbyte(1'b0, "t2_read");
    i2c_stop();

    i2c_start();
    wbyte(8'h2A, 1'b0, "t3_addr_nack");
    check("t3_busy", {31'd0, busy}, 32'd0);
    wbyte(8'h01, 1'b0, "t3_ptr_nack");
    i2c_stop();

    i2c_start();
    wbyte(8'h54, 1'b1, "t4_addr_ack");
    wptr(8'h0F);
    wdata(8'hA1);
    wdata(8'hB2);
    i2c_start();
    wbyte(8'h54, 1'b1, "t4_addr2_ack");
    wptr(8'h0F);
    i2c_start();
    wbyte(8'h55, 1'b1, "t4_raddr_ack");
    rbyte(1'b1, "t4_read_r15");
    rbyte(1'b0, "t4_read_r0");
    i2c_stop();

    i2c_start();
    wbyte(8'h54, 1'b1, "t5_addr_ack");
    wptr(8'h05);
    wdata(8'h5A);
    wdata(8'h6B);
    wdata(8'h7C);
    i2c_stop();
    i2c_start();
    wbyte(8'h54, 1'b1, "t5_addr_ack2");
    wptr(8'h05);
    i2c_start();
    wbyte(8'h55, 1'b1, "t5_sr_addr_ack");
    rbyte(1'b1, "t5_read_r5");
    rbyte(1'b0, "t5_read_r6");
    i2c_stop();
    i2c_start();
    wbyte(8'h55, 1'b1, "t5_persist_ack");
    rbyte(1'b0, "t5_read_r7");
    i2c_stop();

    i2c_start();
    wbyte(8'h54, 1'b1, "t6_addr_ack");
    wptr(8'h00);
    i2c_start();
    wbyte(8'h55, 1'b1, "t6_raddr_ack");
    begin
      logic b;
      rbit(b);
      check("t6_bit7", {31'd0, b}, 32'd1);
    end
    tb_oe = 1'b0; #Q;
    scl = 1'b1; #Q;
    check("t6_drive_low", {31'd0, sda}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_sda_rel", {31'd0, sda}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_wr_addr", {28'd0, wr_addr}, 32'd0);
    check("t6_wr_data", {24'd0, wr_data}, 32'd0);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = '0;
    #Q;
    scl = 1'b0; #Q;
    i2c_stop();

    i2c_start();
    wbyte(8'h55, 1'b1, "t6_post_addr_ack");
    for (int i = 0; i < 16; i++) rbyte(i != 15, "t6_zero_read");
    i2c_stop();
    i2c_start();
    wbyte(8'h54, 1'b1, "t6_w_addr_ack");
    wptr(8'h07);
    wdata(8'h3C);
    i2c_start();
    wbyte(8'h54, 1'b1, "t6_w_addr2_ack");
    wptr(8'h07);
    i2c_start();
    wbyte(8'h55, 1'b1, "t6_r_addr_ack");
    rbyte(1'b0, "t6_readback");
    i2c_stop();

    repeat (10) @(negedge clk);
    check("wr_queue_empty", wr_q.size(), 32'd0);
    check("wr_pulse_count", npulse, nexp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
